fetch_stage: RTL

- Instruction fetch stage plus IF/ID pipeline register, directly upstream of the control decoder.
- Holds the PC and issues requests to instruction memory over a req/ready handshake.
- Registers the fetched word with PC+4 and presents the opcode field [31:26] to the decoder.
- Handles load-use stalls, branch/jump redirects, and memory wait states.

---
 rtl/fetch_stage.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage plus IF/ID pipeline register.
//
// Holds the PC and issues word-aligned requests to instruction memory over a
// req/ready handshake. Each fetched word is registered together with PC+4, and
// the opcode field is presented to the decoder. The stage handles load-use
// stalls through a one-entry skid buffer (HOLD), branch/jump redirects, and
// memory wait states. When a redirect arrives while a request is still
// outstanding, the stage goes to DROP and discards that request.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   stall            hazard hold; freezes IF/ID
//   redirect_valid   taken branch/jump; redirect_pc is the target (bits [1:0] ignored)
//   imem_req/addr    fetch request and word-aligned address (always the registered pc)
//   imem_ready/rdata memory response; it completes when imem_req && imem_ready
//   if_id_valid/instr/pc4  IF/ID register (instr is 0 when invalid)
//   opcode           if_id_instr[31:26], combinational tap for the decoder
//
// Optional feature: define FETCH_PERF_CNT_EN to add the saturating counters
// perf_fetched and perf_bubbles.
module fetch_stage #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(32'h0000_0000)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic                if_id_valid,
  output logic [31:0]         if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_pc4,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_bubbles,
`endif
  output logic [5:0]          opcode
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t              state_r;
  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] pend_pc_r;
  logic [31:0]         skid_instr_r;
  logic [PC_WIDTH-1:0] skid_pc4_r;
  logic                req_r;
  logic                valid_r;
  logic [31:0]         instr_r;
  logic [PC_WIDTH-1:0] pc4_r;

  logic                handshake_s;
  logic [PC_WIDTH-1:0] redirect_tgt_s;
  logic [PC_WIDTH-1:0] pc_plus4_s;

  // Handshake qualifier, aligned redirect target and the wrapping PC+4.
  always_comb begin
    handshake_s    = req_r & imem_ready;
    redirect_tgt_s = redirect_pc & ~PC_WIDTH'(3);
    pc_plus4_s     = pc_r + PC_WIDTH'(4);
  end

  // Fetch FSM with the PC, pending target, skid buffer and IF/ID register.
  // imem_req is registered from the next state. This keeps it low for exactly
  // one cycle after reset is released, which is why every handshake is
  // qualified with req_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_FETCH;
      pc_r         <= RESET_PC;
      pend_pc_r    <= '0;
      skid_instr_r <= 32'h0;
      skid_pc4_r   <= '0;
      req_r        <= 1'b0;
      valid_r      <= 1'b0;
      instr_r      <= 32'h0;
      pc4_r        <= '0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          req_r <= 1'b1;
          if (redirect_valid) begin
            // Redirect beats stall: flush, and never deliver a word returned now.
            valid_r <= 1'b0;
            instr_r <= 32'h0;
            if (handshake_s || !req_r) begin
              pc_r <= redirect_tgt_s;
            end else begin
              pend_pc_r <= redirect_tgt_s;
              state_r   <= ST_DROP;
            end
          end else if (handshake_s) begin
            pc_r <= pc_plus4_s;
            if (stall) begin
              skid_instr_r <= imem_rdata;
              skid_pc4_r   <= pc_plus4_s;
              req_r        <= 1'b0;
              state_r      <= ST_HOLD;
            end else begin
              valid_r <= 1'b1;
              instr_r <= imem_rdata;
              pc4_r   <= pc_plus4_s;
            end
          end else if (!stall) begin
            valid_r <= 1'b0;
            instr_r <= 32'h0;
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            valid_r <= 1'b0;
            instr_r <= 32'h0;
            pc_r    <= redirect_tgt_s;
            req_r   <= 1'b1;
            state_r <= ST_FETCH;
          end else if (!stall) begin
            valid_r <= 1'b1;
            instr_r <= skid_instr_r;
            pc4_r   <= skid_pc4_r;
            req_r   <= 1'b1;
            state_r <= ST_FETCH;
          end else begin
            req_r <= 1'b0;
          end
        end
        ST_DROP: begin
          // imem_addr stays on the old pc until that request completes.
          req_r <= 1'b1;
          if (redirect_valid) begin
            valid_r <= 1'b0;
            instr_r <= 32'h0;
            if (handshake_s) begin
              pc_r    <= redirect_tgt_s;
              state_r <= ST_FETCH;
            end else begin
              pend_pc_r <= redirect_tgt_s;
            end
          end else begin
            if (handshake_s) begin
              pc_r    <= pend_pc_r;
              state_r <= ST_FETCH;
            end
            if (!stall) begin
              valid_r <= 1'b0;
              instr_r <= 32'h0;
            end
          end
        end
        default: begin
          state_r <= ST_FETCH;
          req_r   <= 1'b1;
          valid_r <= 1'b0;
          instr_r <= 32'h0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        deliver_s;
  logic        bubble_s;
  logic [31:0] fetched_r;
  logic [31:0] bubbles_r;

  // Events that load IF/ID: a real word, or a bubble from a flush or a memory wait.
  always_comb begin
    deliver_s = !redirect_valid && !stall &&
                (((state_r == ST_FETCH) && handshake_s) || (state_r == ST_HOLD));
    bubble_s  = redirect_valid ||
                (!stall && (((state_r == ST_FETCH) && req_r && !imem_ready) ||
                            (state_r == ST_DROP)));
  end

  // Saturating performance counters. Stall-hold cycles increment neither counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_r <= 32'h0;
      bubbles_r <= 32'h0;
    end else begin
      if (deliver_s && (fetched_r != 32'hFFFF_FFFF)) fetched_r <= fetched_r + 32'd1;
      if (bubble_s && (bubbles_r != 32'hFFFF_FFFF))  bubbles_r <= bubbles_r + 32'd1;
    end
  end

  assign perf_fetched = fetched_r;
  assign perf_bubbles = bubbles_r;
`endif

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign if_id_valid = valid_r;
  assign if_id_instr = instr_r;
  assign if_id_pc4   = pc4_r;
  assign opcode      = instr_r[31:26];

endmodule
